// File: rtl/vcm_pkg.sv
// Shared types and constants for the VCM focus-step I2C writer.
// Holds the FSM state set, quarter/byte index types and the step-to-byte packing helpers.
package vcm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BYTE  = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4,
    ST_DONE  = 3'd5
  } vcm_state_e;

  typedef logic [1:0] quarter_t;
  typedef logic [1:0] byte_idx_t;

  localparam int unsigned STEP_W            = 10;
  localparam int unsigned B1_STEP_MSB       = 9;
  localparam int unsigned B1_STEP_LSB       = 4;
  localparam int unsigned B2_STEP_MSB       = 3;
  localparam int unsigned QUARTERS_PER_XFER = 116;

  // B1 carries the upper six step bits right-aligned, B2 the lower four left-aligned.
  function automatic logic [7:0] pack_b1(input logic [STEP_W-1:0] step);
    return {2'b00, step[B1_STEP_MSB:B1_STEP_LSB]};
  endfunction

  function automatic logic [7:0] pack_b2(input logic [STEP_W-1:0] step);
    return {step[B2_STEP_MSB:0], 4'b0000};
  endfunction

endpackage

// File: rtl/vcm_step_writer_if.sv
// Step-request handshake plus the I2C pin-level signals of the VCM writer.
// The slave modport is the writer itself; the master modport is its environment.
interface vcm_step_writer_if;
  import vcm_pkg::*;

  logic                CAMERA_I2C_RELAESE;
  logic [STEP_W-1:0]   STEP_REQ;
  logic                STEP_VALID;
  logic                STEP_READY;
  logic                VCM_I2C_SCL;
  logic                SDA_OE;
  logic                SDA_IN;
  logic                VCM_RELAESE;
  logic [STEP_W-1:0]   STEP;
  logic                ACK_ERR;

  modport slave (
    input  CAMERA_I2C_RELAESE, STEP_REQ, STEP_VALID, SDA_IN,
    output STEP_READY, VCM_I2C_SCL, SDA_OE, VCM_RELAESE, STEP, ACK_ERR
  );

  modport master (
    output CAMERA_I2C_RELAESE, STEP_REQ, STEP_VALID, SDA_IN,
    input  STEP_READY, VCM_I2C_SCL, SDA_OE, VCM_RELAESE, STEP, ACK_ERR
  );

endinterface

// File: rtl/i2c_quarter_tick.sv
// Free-running quarter-SCL-period counter; tick marks the last cycle of each quarter.
// Restart forces the count back to zero so a new transaction starts on a full quarter.
module i2c_quarter_tick #(
  parameter int unsigned SCL_QUARTER = 125
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (SCL_QUARTER > 1) ? $clog2(SCL_QUARTER) : 1;
  localparam logic [CW-1:0] TERM = CW'(SCL_QUARTER - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: restart wins, otherwise wrap at terminal count.
  always_comb begin
    count_d = count_q;
    if (restart) begin
      count_d = '0;
    end else if (count_q == TERM) begin
      count_d = '0;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == TERM) && !restart;

endmodule

// File: rtl/vcm_step_writer.sv
// VCM focus writer: after camera config is done, turns each 10-bit step request
// into a 3-byte I2C write {addr+W, step[9:4], step[3:0]<<4} and reports the result.
module vcm_step_writer
  import vcm_pkg::*;
#(
  parameter int unsigned SCL_QUARTER = 125,
  parameter logic [6:0]  VCM_ADDR    = 7'h0C
) (
  input  logic              CLK_50,
  input  logic              RESET,
  vcm_step_writer_if.slave  bus
);

  vcm_state_e        state_q,   state_d;
  quarter_t          qtr_q,     qtr_d;
  logic [2:0]        bit_q,     bit_d;
  byte_idx_t         byte_q,    byte_d;
  logic [7:0]        shift_q,   shift_d;
  logic [STEP_W-1:0] shadow_q,  shadow_d;
  logic [STEP_W-1:0] step_q,    step_d;
  logic              fail_q,    fail_d;
  logic              scl_q,     scl_d;
  logic              sda_oe_q,  sda_oe_d;
  logic              rel_q,     rel_d;
  logic              ready_q,   ready_d;
  logic              ack_err_q, ack_err_d;
  logic              accept;
  logic              tick;

  assign accept = (state_q == ST_IDLE) && ready_q && bus.STEP_VALID;

  i2c_quarter_tick #(.SCL_QUARTER(SCL_QUARTER)) u_tick (
    .clk     (CLK_50),
    .rst     (RESET),
    .restart (accept),
    .tick    (tick)
  );

  // Sequencing: quarters advance on tick; states change on the last quarter of a slot.
  always_comb begin
    state_d   = state_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    shift_d   = shift_q;
    shadow_d  = shadow_q;
    step_d    = step_q;
    fail_d    = fail_q;
    ack_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_START;
          qtr_d    = 2'd0;
          bit_d    = 3'd0;
          byte_d   = 2'd0;
          fail_d   = 1'b0;
          shadow_d = bus.STEP_REQ;
          shift_d  = {VCM_ADDR, 1'b0};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            state_d = ST_BYTE;
          end else begin
            state_d = ST_START;
          end
        end else begin
          qtr_d = qtr_q;
        end
      end
      ST_BYTE: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            if (bit_q == 3'd7) begin
              state_d = ST_ACK;
              bit_d   = 3'd0;
            end else begin
              bit_d   = bit_q + 3'd1;
              shift_d = {shift_q[6:0], 1'b0};
            end
          end else begin
            state_d = ST_BYTE;
          end
        end else begin
          qtr_d = qtr_q;
        end
      end
      ST_ACK: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd2) begin
            fail_d = bus.SDA_IN;
          end else if (qtr_q == 2'd3) begin
            // A NACK skips the remaining bytes and goes straight to STOP.
            if (fail_q || (byte_q == 2'd2)) begin
              state_d = ST_STOP;
            end else begin
              state_d = ST_BYTE;
              byte_d  = byte_q + 2'd1;
              if (byte_q == 2'd0) begin
                shift_d = pack_b1(shadow_q);
              end else begin
                shift_d = pack_b2(shadow_q);
              end
            end
          end else begin
            fail_d = fail_q;
          end
        end else begin
          qtr_d = qtr_q;
        end
      end
      ST_STOP: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            state_d = ST_DONE;
            if (fail_q) begin
              ack_err_d = 1'b1;
            end else begin
              step_d = shadow_q;
            end
          end else begin
            state_d = ST_STOP;
          end
        end else begin
          qtr_d = qtr_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pin levels for the slot being entered, so the pins are plain flops.
  always_comb begin
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    case (state_d)
      ST_START: begin
        scl_d    = (qtr_d < 2'd2);
        sda_oe_d = (qtr_d != 2'd0);
      end
      ST_BYTE: begin
        scl_d    = (qtr_d == 2'd1) || (qtr_d == 2'd2);
        sda_oe_d = ~shift_d[7];
      end
      ST_ACK: begin
        scl_d    = (qtr_d == 2'd1) || (qtr_d == 2'd2);
        sda_oe_d = 1'b0;
      end
      ST_STOP: begin
        scl_d    = (qtr_d != 2'd0);
        sda_oe_d = (qtr_d < 2'd2);
      end
      default: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
      end
    endcase
    rel_d   = (state_d == ST_IDLE) || (state_d == ST_DONE);
    ready_d = (state_d == ST_IDLE) && bus.CAMERA_I2C_RELAESE;
  end

  // State and output registers.
  always_ff @(posedge CLK_50) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd0;
      byte_q    <= 2'd0;
      shift_q   <= 8'h00;
      shadow_q  <= 10'd0;
      step_q    <= 10'd0;
      fail_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
      rel_q     <= 1'b1;
      ready_q   <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      shift_q   <= shift_d;
      shadow_q  <= shadow_d;
      step_q    <= step_d;
      fail_q    <= fail_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
      rel_q     <= rel_d;
      ready_q   <= ready_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign bus.STEP_READY  = ready_q;
  assign bus.VCM_I2C_SCL = scl_q;
  assign bus.SDA_OE      = sda_oe_q;
  assign bus.VCM_RELAESE = rel_q;
  assign bus.STEP        = step_q;
  assign bus.ACK_ERR     = ack_err_q;

endmodule
